// File: rtl/sr_ff_monitor.sv
// sr_ff_monitor
//   Response monitor for the sr_ff cell. Tracks the S/R commands driven to
//   the cell with a reference predictor, then checks the cell's Q/Q_bar one
//   edge after each command that leaves the predictor in a KNOWN state.
//   Reports illegal S=R=1 commands, Q mismatches, Q/Q_bar complement
//   violations, saturating error/check counters and the check index of the
//   first failure.
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   en, S, R            : command qualifier and the S/R command sent to the cell
//   Q, Q_bar            : cell outputs under observation
//   exp_q, known        : predicted Q and predictor validity
//   illegal             : 1-cycle pulse, S=R=1 sampled with en=1
//   mismatch, comp_err  : 1-cycle pulses from an armed check
//   fail                : sticky error flag
//   err_cnt, chk_cnt    : saturating error / check counters
//   first_err_idx       : chk_cnt value at the first erroneous check
module sr_ff_monitor #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             S,
  input  logic             R,
  input  logic             Q,
  input  logic             Q_bar,
  output logic             exp_q,
  output logic             known,
  output logic             illegal,
  output logic             mismatch,
  output logic             comp_err,
  output logic             fail,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] first_err_idx
);

  localparam logic [0:0] ST_UNK   = 1'b0;
  localparam logic [0:0] ST_KNOWN = 1'b1;

  logic [0:0]       state_q, state_d;
  logic             exp_q_q, exp_q_d;
  logic             arm_q, arm_d;
  logic             illegal_q, illegal_d;
  logic             mismatch_q, mismatch_d;
  logic             comp_err_q, comp_err_d;
  logic             fail_q, fail_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] chk_cnt_q, chk_cnt_d;
  logic [CNT_W-1:0] first_err_idx_q, first_err_idx_d;
  logic             chk_bad;

  // Predictor: next state/expected Q from the command sampled this edge.
  always_comb begin
    state_d   = state_q;
    exp_q_d   = exp_q_q;
    illegal_d = 1'b0;
    if (en) begin
      case ({S, R})
        2'b10: begin
          exp_q_d = 1'b1;
          state_d = ST_KNOWN;
        end
        2'b01: begin
          exp_q_d = 1'b0;
          state_d = ST_KNOWN;
        end
        2'b11: begin
          state_d   = ST_UNK;
          illegal_d = 1'b1;
        end
        default: ;
      endcase
    end
    // The cell reacts to this command at the same edge, so its response is
    // checked one edge later against the exp_q registered now.
    arm_d = en & (state_d == ST_KNOWN);
  end

  // Checker: runs on the command armed at the previous edge, using the
  // pre-update exp_q_q, independent of en at this edge.
  always_comb begin
    mismatch_d      = 1'b0;
    comp_err_d      = 1'b0;
    chk_bad         = 1'b0;
    fail_d          = fail_q;
    err_cnt_d       = err_cnt_q;
    chk_cnt_d       = chk_cnt_q;
    first_err_idx_d = first_err_idx_q;
    if (arm_q) begin
      mismatch_d = (Q != exp_q_q);
      comp_err_d = (Q_bar == Q);
      chk_bad    = mismatch_d | comp_err_d;
      if (chk_cnt_q != '1) chk_cnt_d = chk_cnt_q + CNT_W'(1);
      if (chk_bad) begin
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
        fail_d = 1'b1;
        if (!fail_q) first_err_idx_d = chk_cnt_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_UNK;
      exp_q_q         <= 1'b0;
      arm_q           <= 1'b0;
      illegal_q       <= 1'b0;
      mismatch_q      <= 1'b0;
      comp_err_q      <= 1'b0;
      fail_q          <= 1'b0;
      err_cnt_q       <= '0;
      chk_cnt_q       <= '0;
      first_err_idx_q <= '0;
    end else begin
      state_q         <= state_d;
      exp_q_q         <= exp_q_d;
      arm_q           <= arm_d;
      illegal_q       <= illegal_d;
      mismatch_q      <= mismatch_d;
      comp_err_q      <= comp_err_d;
      fail_q          <= fail_d;
      err_cnt_q       <= err_cnt_d;
      chk_cnt_q       <= chk_cnt_d;
      first_err_idx_q <= first_err_idx_d;
    end
  end

  assign exp_q         = exp_q_q;
  assign known         = (state_q == ST_KNOWN);
  assign illegal       = illegal_q;
  assign mismatch      = mismatch_q;
  assign comp_err      = comp_err_q;
  assign fail          = fail_q;
  assign err_cnt       = err_cnt_q;
  assign chk_cnt       = chk_cnt_q;
  assign first_err_idx = first_err_idx_q;

endmodule

// File: tb/tb_sr_ff_monitor.sv
// tb_sr_ff_monitor
//   Drives two monitors (CNT_W=8 and CNT_W=2) from an emulated sr_ff cell
//   with selectable faults; directed scenarios use fixed expectations,
//   the random scenario uses a transaction-level reference model.
module tb_sr_ff_monitor;

  logic clk = 1'b0;
  logic rst, en, S, R, Q, Q_bar;

  logic       exp_q, known, illegal, mismatch, comp_err, fail;
  logic [7:0] err_cnt, chk_cnt, first_err_idx;
  logic       exp_q2, known2, illegal2, mismatch2, comp_err2, fail2;
  logic [1:0] err_cnt2, chk_cnt2, first_err_idx2;

  int n_pass  = 0;
  int n_total = 0;

  // Emulated cell: state and fault mode
  // 0 good, 1 Q stuck 0, 2 Q_bar tied to Q, 3 Q inverted and Q_bar tied to Q
  logic dut_q;
  int   fault;

  // Reference model (index 0: CNT_W=8, index 1: CNT_W=2)
  logic m_known, m_exp, m_ill, m_mm, m_ce, m_fail;
  int   m_err[2], m_chk[2], m_first[2];
  int   m_max[2] = '{255, 3};
  logic pendq[$];   // expected Q for each command awaiting its check

  sr_ff_monitor #(.CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .en(en), .S(S), .R(R), .Q(Q), .Q_bar(Q_bar),
    .exp_q(exp_q), .known(known), .illegal(illegal), .mismatch(mismatch),
    .comp_err(comp_err), .fail(fail), .err_cnt(err_cnt), .chk_cnt(chk_cnt),
    .first_err_idx(first_err_idx)
  );

  sr_ff_monitor #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .S(S), .R(R), .Q(Q), .Q_bar(Q_bar),
    .exp_q(exp_q2), .known(known2), .illegal(illegal2), .mismatch(mismatch2),
    .comp_err(comp_err2), .fail(fail2), .err_cnt(err_cnt2), .chk_cnt(chk_cnt2),
    .first_err_idx(first_err_idx2)
  );

  always #5 clk = ~clk;

  task automatic drive_cell();
    case (fault)
      1:       begin Q = 1'b0;   Q_bar = 1'b1;   end
      2:       begin Q = dut_q;  Q_bar = dut_q;  end
      3:       begin Q = ~dut_q; Q_bar = ~dut_q; end
      default: begin Q = dut_q;  Q_bar = ~dut_q; end
    endcase
  endtask

  // One clock: apply inputs, take the edge, advance model and cell, settle.
  task automatic step(input logic e, input logic s, input logic r, input logic do_rst);
    logic qs, qbs, have, pe;
    rst = do_rst; en = e; S = s; R = r;
    qs = Q; qbs = Q_bar;
    @(posedge clk);
    #1;
    if (do_rst) begin
      m_known = 0; m_exp = 0; m_ill = 0; m_mm = 0; m_ce = 0; m_fail = 0;
      for (int k = 0; k < 2; k++) begin m_err[k] = 0; m_chk[k] = 0; m_first[k] = 0; end
      pendq.delete();
      dut_q = 1'b0;
    end else begin
      have = (pendq.size() != 0);
      pe   = have ? pendq.pop_front() : 1'b0;
      m_mm = have && (qs != pe);
      m_ce = have && (qbs == qs);
      for (int k = 0; k < 2; k++) begin
        if (have && (m_mm || m_ce)) begin
          if (!m_fail) m_first[k] = m_chk[k];
          m_err[k] = (m_err[k] + 1 > m_max[k]) ? m_max[k] : m_err[k] + 1;
        end
        if (have) m_chk[k] = (m_chk[k] + 1 > m_max[k]) ? m_max[k] : m_chk[k] + 1;
      end
      if (m_mm || m_ce) m_fail = 1;
      m_ill = e && s && r;
      if (e) begin
        if (s && !r)      begin m_exp = 1; m_known = 1; end
        else if (!s && r) begin m_exp = 0; m_known = 1; end
        else if (s && r)  m_known = 0;
        if (m_known) pendq.push_back(m_exp);
      end
      if (s && !r) dut_q = 1'b1;
      else if (!s && r) dut_q = 1'b0;
    end
    drive_cell();
  endtask

  task automatic test_reset();
    fault = 0;
    step(0, 0, 0, 1);
    n_total++; if (known !== 1'b0 || exp_q !== 1'b0) $display("FAIL reset_pred: known=%0b exp_q=%0b want 0 0", known, exp_q); else n_pass++;
    n_total++; if (err_cnt !== 8'd0 || chk_cnt !== 8'd0 || first_err_idx !== 8'd0) $display("FAIL reset_cnt: err=%0d chk=%0d first=%0d want 0 0 0", err_cnt, chk_cnt, first_err_idx); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0);
      n_total++;
      if (known !== 1'b0 || chk_cnt !== 8'd0 || illegal !== 1'b0 || mismatch !== 1'b0 || comp_err !== 1'b0 || fail !== 1'b0)
        $display("FAIL hold_unk[%0d]: known=%0b chk=%0d ill=%0b mm=%0b ce=%0b fail=%0b want all 0", i, known, chk_cnt, illegal, mismatch, comp_err, fail);
      else n_pass++;
    end
  endtask

  task automatic test_good_sequence();
    logic [1:0] cmd [4] = '{2'b10, 2'b00, 2'b01, 2'b00};
    logic       want[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    fault = 0;
    step(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, cmd[i][1], cmd[i][0], 0);
      n_total++; if (exp_q !== want[i] || known !== 1'b1) $display("FAIL seq_exp[%0d]: exp_q=%0b known=%0b want %0b 1", i, exp_q, known, want[i]); else n_pass++;
    end
    step(0, 0, 0, 0);
    n_total++; if (chk_cnt !== 8'd4) $display("FAIL seq_chk: chk=%0d want 4", chk_cnt); else n_pass++;
    n_total++; if (err_cnt !== 8'd0 || fail !== 1'b0) $display("FAIL seq_err: err=%0d fail=%0b want 0 0", err_cnt, fail); else n_pass++;
  endtask

  task automatic test_illegal();
    fault = 0;
    step(0, 0, 0, 1);
    step(1, 1, 1, 0);
    n_total++; if (illegal !== 1'b1 || known !== 1'b0) $display("FAIL ill_pulse: ill=%0b known=%0b want 1 0", illegal, known); else n_pass++;
    step(1, 1, 0, 0);
    n_total++; if (illegal !== 1'b0 || known !== 1'b1 || chk_cnt !== 8'd0) $display("FAIL ill_after: ill=%0b known=%0b chk=%0d want 0 1 0", illegal, known, chk_cnt); else n_pass++;
    step(0, 0, 0, 0);
    n_total++; if (chk_cnt !== 8'd1 || mismatch !== 1'b0) $display("FAIL ill_check: chk=%0d mm=%0b want 1 0", chk_cnt, mismatch); else n_pass++;
  endtask

  task automatic test_mismatch();
    fault = 1;
    step(0, 0, 0, 1);
    step(1, 1, 0, 0);
    n_total++; if (mismatch !== 1'b0 || fail !== 1'b0) $display("FAIL mm_early: mm=%0b fail=%0b want 0 0", mismatch, fail); else n_pass++;
    step(0, 0, 0, 0);
    n_total++;
    if (mismatch !== 1'b1 || comp_err !== 1'b0 || err_cnt !== 8'd1 || fail !== 1'b1 || first_err_idx !== 8'd0)
      $display("FAIL mm_hit: mm=%0b ce=%0b err=%0d fail=%0b first=%0d want 1 0 1 1 0", mismatch, comp_err, err_cnt, fail, first_err_idx);
    else n_pass++;
    step(0, 0, 0, 0);
    n_total++; if (mismatch !== 1'b0 || fail !== 1'b1) $display("FAIL mm_after: mm=%0b fail=%0b want 0 1", mismatch, fail); else n_pass++;
  endtask

  task automatic test_comp_err();
    fault = 2;
    step(0, 0, 0, 1);
    step(1, 0, 1, 0);
    step(0, 0, 0, 0);
    n_total++;
    if (comp_err !== 1'b1 || mismatch !== 1'b0 || err_cnt !== 8'd1)
      $display("FAIL ce_hit: ce=%0b mm=%0b err=%0d want 1 0 1", comp_err, mismatch, err_cnt);
    else n_pass++;
    fault = 3;
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    n_total++;
    if (comp_err !== 1'b1 || mismatch !== 1'b1 || err_cnt !== 8'd2 || chk_cnt !== 8'd2 || first_err_idx !== 8'd0)
      $display("FAIL ce_both: ce=%0b mm=%0b err=%0d chk=%0d first=%0d want 1 1 2 2 0", comp_err, mismatch, err_cnt, chk_cnt, first_err_idx);
    else n_pass++;
  endtask

  task automatic test_saturation();
    fault = 1;
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    n_total++; if (err_cnt2 !== 2'd3 || chk_cnt2 !== 2'd3) $display("FAIL sat_w2: err=%0d chk=%0d want 3 3", err_cnt2, chk_cnt2); else n_pass++;
    n_total++; if (err_cnt !== 8'd5 || first_err_idx2 !== 2'd0) $display("FAIL sat_w8: err=%0d first2=%0d want 5 0", err_cnt, first_err_idx2); else n_pass++;
    step(0, 0, 0, 0);
    n_total++; if (err_cnt2 !== 2'd3 || fail2 !== 1'b1) $display("FAIL sat_hold: err=%0d fail=%0b want 3 1", err_cnt2, fail2); else n_pass++;
    step(1, 1, 0, 0);
    step(1, 1, 0, 1);
    n_total++;
    if (exp_q2 !== 1'b0 || known2 !== 1'b0 || illegal2 !== 1'b0 || mismatch2 !== 1'b0 || comp_err2 !== 1'b0 ||
        fail2 !== 1'b0 || err_cnt2 !== 2'd0 || chk_cnt2 !== 2'd0 || first_err_idx2 !== 2'd0)
      $display("FAIL mid_rst: exp=%0b known=%0b ill=%0b mm=%0b ce=%0b fail=%0b err=%0d chk=%0d first=%0d want all 0",
               exp_q2, known2, illegal2, mismatch2, comp_err2, fail2, err_cnt2, chk_cnt2, first_err_idx2);
    else n_pass++;
    step(0, 0, 0, 0);
    n_total++; if (chk_cnt !== 8'd0 || mismatch !== 1'b0) $display("FAIL rst_drop: chk=%0d mm=%0b want 0 0", chk_cnt, mismatch); else n_pass++;
  endtask

  task automatic test_random();
    fault = 0;
    step(0, 0, 0, 1);
    for (int i = 0; i < 600; i++) begin
      if (i % 24 == 0) fault = int'($urandom_range(0, 3));
      step(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), ($urandom_range(0, 99) == 0));
      n_total++;
      if (known !== m_known || illegal !== m_ill || mismatch !== m_mm || comp_err !== m_ce || fail !== m_fail || (m_known && exp_q !== m_exp))
        $display("FAIL rnd_flags[%0d]: known=%0b ill=%0b mm=%0b ce=%0b fail=%0b exp=%0b want %0b %0b %0b %0b %0b %0b",
                 i, known, illegal, mismatch, comp_err, fail, exp_q, m_known, m_ill, m_mm, m_ce, m_fail, m_exp);
      else n_pass++;
      n_total++;
      if (int'(err_cnt) != m_err[0] || int'(chk_cnt) != m_chk[0] || int'(first_err_idx) != m_first[0])
        $display("FAIL rnd_cnt8[%0d]: err=%0d chk=%0d first=%0d want %0d %0d %0d",
                 i, err_cnt, chk_cnt, first_err_idx, m_err[0], m_chk[0], m_first[0]);
      else n_pass++;
      n_total++;
      if (int'(err_cnt2) != m_err[1] || int'(chk_cnt2) != m_chk[1] || int'(first_err_idx2) != m_first[1] || fail2 !== m_fail)
        $display("FAIL rnd_cnt2[%0d]: err=%0d chk=%0d first=%0d fail=%0b want %0d %0d %0d %0b",
                 i, err_cnt2, chk_cnt2, first_err_idx2, fail2, m_err[1], m_chk[1], m_first[1], m_fail);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; S = 1'b0; R = 1'b0;
    dut_q = 1'b0; fault = 0;
    drive_cell();
    @(negedge clk);
    test_reset();
    test_good_sequence();
    test_illegal();
    test_mismatch();
    test_comp_err();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
